rle_row_decoder: RTL and testbench
==================================

// Module: rle_row_decoder
// PURPOSE
//  Inverse of the frame-difference RLE encoder: accepts (value, count, start_x) run records and rebuilds one video row.
//  Each x in 0..ChannelLength-1 gets the run value if a record covers it, else the previous-frame pixel.
//  Sits between the UART receive path (record source) and the frame buffer / VGA line writer (pixel sink).
// PARAMETERS
//  ChannelLength  640  pixels per row
//  MaxRunLength   12   max run count; count width is $clog2(MaxRunLength)
//  FifoDepth      4    record FIFO entries, power of two
// PORTS
//  CLK          in   1        clock
//  RST          in   1        reset; synchronous, active-high
//  i_valid      in   1        record present on i_val/i_count/i_start_x
//  i_val        in   8        run value
//  i_count      in   CW       run length, CW=$clog2(MaxRunLength)
//  i_start_x    in   XW       first x of run, XW=$clog2(ChannelLength)
//  o_full       out  1        FIFO full; records offered while high are dropped
//  i_row_start  in   1        begin emitting a row (honoured only in IDLE)
//  i_prev_val   in   8        previous-frame pixel at o_x, supplied combinationally by the sink
//  i_pix_ready  in   1        sink accepts o_pix this cycle
//  o_pix_valid  out  1        o_pix/o_x valid
//  o_pix        out  8        reconstructed pixel; 0 when o_pix_valid low
//  o_x          out  XW       x of o_pix
//  o_row_done   out  1        one-cycle pulse after last pixel accepted
// BEHAVIOUR
//  Reset: FIFO empty, o_full=0, o_pix_valid=0, o_pix=0, o_x=0, o_row_done=0, state IDLE, o_run_px=0.
//  RST mid-row aborts the row and flushes the FIFO; no o_row_done.
//  Push: i_valid && !o_full. Push when full is ignored even if a pop occurs that cycle. Push+pop when not full: level unchanged.
//  FSM IDLE -> EMIT on i_row_start (o_pix_valid=1 next cycle, o_x=0). EMIT -> DONE on accept at x=ChannelLength-1.
//  DONE: o_row_done=1 for one cycle -> IDLE. i_row_start outside IDLE ignored.
//  Head end = start_x+count, computed XW+1 bits (no wrap).
//  Covers: x>=start_x && x<end.
//  Stale head (count==0 or end<=x): popped, o_pix_valid=0 that cycle, x not advanced.
//  EMIT: o_pix = covers ? head.val : i_prev_val (combinational).
//  Accept (o_pix_valid && i_pix_ready): x increments.
//  On accept with covers && x==end-1: head is popped.
//  !i_pix_ready: o_x and o_pix held (o_pix tracks i_prev_val if not covered).
//  Run past ChannelLength-1: truncated; a head covering the last x is popped at row end.
//  Records whose start_x is beyond the current x stay queued for this row. Records left at row end carry into the next row.
//  Records must arrive in ascending start_x; out-of-order records become stale and are dropped.
// CONFIGURATION
//  RLE_DEC_STATS_EN defined: adds port o_run_px out XW+1, count of run-sourced pixels in the last row.
//  o_run_px is updated in DONE and held otherwise.
//  RLE_DEC_STATS_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  rle_defs.vh (shared with the encoder): width localparams CW/XW and FSM encodings IDLE/EMIT/DONE.
//  Sub-module rle_run_fifo: synchronous FIFO of {val,count,start_x}; ports push/pop/full/empty/head.
//  Top holds the FSM, x counter, coverage compare and output mux.
// TESTING
//  No records, i_prev_val=o_x[7:0], ready=1 -> 640 pixels equal x[7:0]; o_row_done pulses once, 1 cycle after x=639.
//  Record (0x80,3,10) -> x10..12=0x80, else prev; FIFO empty after x=12 accepted.
//  Records (0x10,2,5),(0x20,4,6) -> x5,6=0x10; x7..9=0x20; x10=prev.
//  Record (0x55,11,635) -> x635..639=0x55; popped at row end; next row all prev.
//  5 pushes into empty FIFO, no row -> o_full after 4th; 5th dropped.
//  Same 5-push test, continued: i_pix_ready=0 for 3 cycles at x=10 -> o_x=10 held; 4 records decode correctly.
//  RST at x=100 -> next cycle o_pix_valid=0, FIFO empty, IDLE. With RLE_DEC_STATS_EN, the (0x80,3,10) row gives o_run_px=3.

Source files
------------

// File: rtl/rle_row_decoder_pkg.sv
// Shared widths, FSM encoding and run record layout for the RLE row decoder.
// Optional statistics port is enabled with RLE_DEC_STATS_EN.
package rle_row_decoder_pkg;

  localparam int ChannelLength = 640;
  localparam int MaxRunLength  = 12;
  localparam int FifoDepth     = 4;

  localparam int CW = $clog2(MaxRunLength);
  localparam int XW = $clog2(ChannelLength);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0]    val;
    logic [CW-1:0] count;
    logic [XW-1:0] start_x;
  } rec_t;

  // One past the last x of a run, one bit wider so it never wraps.
  function automatic logic [XW:0] run_end(rec_t r);
    return {1'b0, r.start_x} + (XW+1)'(r.count);
  endfunction

endpackage

// File: rtl/rle_row_decoder_fifo.sv
// Small synchronous FIFO holding pending run records.
// A push while full is dropped even if a pop happens in the same cycle.
module rle_run_fifo
  import rle_row_decoder_pkg::*;
#(
  parameter int Depth = FifoDepth
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  rec_t din,
  output logic full,
  output logic empty,
  output rec_t head
);

  localparam int AW = $clog2(Depth);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  rec_t        mem_q [Depth];
  rec_t        mem_d [Depth];
  logic        do_push;
  logic        do_pop;

  // Pointer arithmetic and storage write
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW-1:0] == rd_q[AW-1:0])
           && (wr_q[AW] != rd_q[AW]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem_q[rd_q[AW-1:0]];
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = din;
  end

  // Pointer and storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rle_row_decoder.sv
// Rebuilds one video row from queued (value, count, start_x) run records.
// Define RLE_DEC_STATS_EN to add o_run_px, the run-pixel count of the last row.
module rle_row_decoder
  import rle_row_decoder_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_valid,
  input  logic [7:0]    i_val,
  input  logic [CW-1:0] i_count,
  input  logic [XW-1:0] i_start_x,
  output logic          o_full,
  input  logic          i_row_start,
  input  logic [7:0]    i_prev_val,
  input  logic          i_pix_ready,
  output logic          o_pix_valid,
  output logic [7:0]    o_pix,
  output logic [XW-1:0] o_x,
  output logic          o_row_done
`ifdef RLE_DEC_STATS_EN
  ,
  output logic [XW:0]   o_run_px
`endif
);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  rec_t          din;
  rec_t          head;
  logic          empty;
  logic          pop;
  logic [XW:0]   head_end;
  logic [XW:0]   x_ext;
  logic          stale;
  logic          covers;
  logic          last_x;
  logic          accept;

  assign din = '{val: i_val, count: i_count, start_x: i_start_x};

  rle_run_fifo u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (i_valid),
    .pop   (pop),
    .din   (din),
    .full  (o_full),
    .empty (empty),
    .head  (head)
  );

  // Coverage compare, output mux and head retirement
  always_comb begin
    head_end    = run_end(head);
    x_ext       = {1'b0, x_q};
    last_x      = (x_q == XW'(ChannelLength - 1));
    stale       = (state_q == EMIT) && !empty
               && (head.count == '0 || head_end <= x_ext);
    covers      = !empty && head.count != '0
               && x_ext >= {1'b0, head.start_x}
               && x_ext < head_end;
    o_pix_valid = (state_q == EMIT) && !stale;
    accept      = o_pix_valid && i_pix_ready;
    o_pix       = '0;
    if (o_pix_valid) o_pix = covers ? head.val : i_prev_val;
    pop         = stale
               || (accept && covers
                   && (x_ext == head_end - (XW+1)'(1) || last_x));
    o_x         = x_q;
    o_row_done  = (state_q == DONE);
  end

  // Row FSM and x counter
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: begin
        if (i_row_start) begin
          state_d = EMIT;
          x_d     = '0;
        end
      end
      EMIT: begin
        if (accept) begin
          if (last_x) begin
            state_d = DONE;
            x_d     = '0;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and x registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
    end
  end

`ifdef RLE_DEC_STATS_EN
  logic [XW:0] run_cnt_q, run_cnt_d;
  logic [XW:0] run_px_q, run_px_d;

  // Count run-sourced pixels, publish at row end
  always_comb begin
    run_cnt_d = run_cnt_q;
    run_px_d  = run_px_q;
    if (state_q == IDLE && i_row_start) run_cnt_d = '0;
    else if (accept && covers) run_cnt_d = run_cnt_q + 1'b1;
    if (state_q == DONE) run_px_d = run_cnt_q;
  end

  // Statistics registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      run_cnt_q <= '0;
      run_px_q  <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
      run_px_q  <= run_px_d;
    end
  end

  assign o_run_px = run_px_q;
`endif

endmodule

// File: tb/tb_rle_row_decoder.sv
// Scoreboard bench for rle_row_decoder: directed rows with hand-built runs.
// Expected pixels are queued per row; a negedge monitor pops and compares.
module tb_rle_row_decoder;
  import rle_row_decoder_pkg::*;

  logic          clk = 1'b0;
  logic          RST;
  logic          i_valid;
  logic [7:0]    i_val;
  logic [CW-1:0] i_count;
  logic [XW-1:0] i_start_x;
  logic          o_full;
  logic          i_row_start;
  logic [7:0]    i_prev_val;
  logic          i_pix_ready;
  logic          o_pix_valid;
  logic [7:0]    o_pix;
  logic [XW-1:0] o_x;
  logic          o_row_done;
`ifdef RLE_DEC_STATS_EN
  logic [XW:0]   o_run_px;
`endif

  typedef struct packed {
    logic [XW-1:0] x;
    logic [7:0]    pix;
  } exp_t;

  exp_t exp_q[$];
  rec_t pend_q[$];
  int   checks = 0;
  int   fails = 0;
  int   done_cnt = 0;
  bit   prev_last = 1'b0;

  always #5 clk = ~clk;

  assign i_prev_val = o_x[7:0];

  rle_row_decoder dut (
    .CLK         (clk),
    .RST         (RST),
    .i_valid     (i_valid),
    .i_val       (i_val),
    .i_count     (i_count),
    .i_start_x   (i_start_x),
    .o_full      (o_full),
    .i_row_start (i_row_start),
    .i_prev_val  (i_prev_val),
    .i_pix_ready (i_pix_ready),
    .o_pix_valid (o_pix_valid),
    .o_pix       (o_pix),
    .o_x         (o_x),
    .o_row_done  (o_row_done)
`ifdef RLE_DEC_STATS_EN
    ,
    .o_run_px    (o_run_px)
`endif
  );

  always @(negedge clk) begin
    exp_t e;
    if (!RST) begin
      if (o_pix_valid && i_pix_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL pix_extra x=%0d got=%02h required none",
                   o_x, o_pix);
        end else begin
          e = exp_q.pop_front();
          if (o_x != e.x || o_pix != e.pix) begin
            fails++;
            $display("FAIL pix x=%0d pix=%02h required x=%0d pix=%02h",
                     o_x, o_pix, e.x, e.pix);
          end
        end
      end else if (!o_pix_valid) begin
        checks++;
        if (o_pix != 8'h00) begin
          fails++;
          $display("FAIL pix_idle got=%02h required 00", o_pix);
        end
      end
      if (o_row_done) begin
        checks++;
        done_cnt++;
        if (!prev_last || exp_q.size() != 0) begin
          fails++;
          $display("FAIL row_done after_last=%0d left=%0d required 1/0",
                   prev_last, exp_q.size());
        end
      end
      prev_last = o_pix_valid && i_pix_ready
               && (o_x == XW'(ChannelLength - 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_rec(input logic [7:0] v, input int c,
                          input int s, input bit kept);
    rec_t r;
    r.val     = v;
    r.count   = CW'(c);
    r.start_x = XW'(s);
    i_valid   = 1'b1;
    i_val     = r.val;
    i_count   = r.count;
    i_start_x = r.start_x;
    if (kept) pend_q.push_back(r);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic expect_row();
    logic [7:0] row [ChannelLength];
    exp_t e;
    for (int x = 0; x < ChannelLength; x++) row[x] = x[7:0];
    for (int i = pend_q.size() - 1; i >= 0; i--) begin
      for (int k = 0; k < int'(pend_q[i].count); k++) begin
        if (int'(pend_q[i].start_x) + k < ChannelLength)
          row[int'(pend_q[i].start_x) + k] = pend_q[i].val;
      end
    end
    for (int x = 0; x < ChannelLength; x++) begin
      e.x   = XW'(x);
      e.pix = row[x];
      exp_q.push_back(e);
    end
    pend_q.delete();
  endtask

  task automatic run_row(input int stall_x, input logic [7:0] stall_pix);
    int d0;
    int cyc;
    bit stalled;
    d0      = done_cnt;
    cyc     = 0;
    stalled = 1'b0;
    expect_row();
    i_row_start = 1'b1;
    tick();
    i_row_start = 1'b0;
    while (done_cnt == d0 && cyc < 3000) begin
      if (!stalled && stall_x >= 0 && o_pix_valid && o_x == XW'(stall_x)) begin
        stalled     = 1'b1;
        i_pix_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("stall_x", int'(o_x), stall_x);
          chk("stall_pix", int'(o_pix), int'(stall_pix));
        end
        i_pix_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    chk("row_timeout", int'(done_cnt == d0), 0);
    chk("row_left", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    int cyc;
    RST         = 1'b1;
    i_valid     = 1'b0;
    i_val       = '0;
    i_count     = '0;
    i_start_x   = '0;
    i_row_start = 1'b0;
    i_pix_ready = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_valid", int'(o_pix_valid), 0);
    chk("rst_pix", int'(o_pix), 0);
    chk("rst_x", int'(o_x), 0);
    chk("rst_done", int'(o_row_done), 0);
    chk("rst_full", int'(o_full), 0);
`ifdef RLE_DEC_STATS_EN
    chk("rst_run_px", int'(o_run_px), 0);
`endif

    run_row(-1, 8'h00);

    push_rec(8'h80, 3, 10, 1'b1);
    run_row(-1, 8'h00);
`ifdef RLE_DEC_STATS_EN
    chk("run_px", int'(o_run_px), 3);
`endif

    push_rec(8'h10, 2, 5, 1'b1);
    push_rec(8'h20, 4, 6, 1'b1);
    run_row(-1, 8'h00);

    push_rec(8'h55, 11, 635, 1'b1);
    run_row(-1, 8'h00);
    run_row(-1, 8'h00);

    push_rec(8'h11, 2, 3, 1'b1);
    push_rec(8'h22, 1, 8, 1'b1);
    push_rec(8'h33, 3, 10, 1'b1);
    chk("full_after3", int'(o_full), 0);
    push_rec(8'h44, 2, 20, 1'b1);
    chk("full_after4", int'(o_full), 1);
    push_rec(8'h99, 2, 30, 1'b0);
    chk("full_after5", int'(o_full), 1);
    run_row(10, 8'h33);
    chk("full_drained", int'(o_full), 0);

    push_rec(8'hAA, 5, 200, 1'b1);
    expect_row();
    i_row_start = 1'b1;
    tick();
    i_row_start = 1'b0;
    cyc = 0;
    while (!(o_pix_valid && o_x == XW'(100)) && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("reach_x100", int'(o_x), 100);
    d0  = done_cnt;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_valid", int'(o_pix_valid), 0);
    chk("abort_x", int'(o_x), 0);
    chk("abort_full", int'(o_full), 0);
    exp_q.delete();
    pend_q.delete();
    repeat (3) tick();
    chk("abort_no_done", done_cnt, d0);
    run_row(-1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
